// File: rtl/rf_pkg.sv
// Shared default constants for the scoreboarded integer register file.
package rf_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned SP_IDX   = 2;
  localparam logic [31:0] SP_INIT  = 32'h2ffc;
  // a7 holds the syscall number checked on ecall
  localparam int unsigned HALT_REG = 17;
  localparam int unsigned HALT_VAL = 10;

endpackage

// File: rtl/rf_read_port.sv
// One asynchronous read port: x0 masking, optional writeback bypass and
// per-port hazard detection. Bypass is enabled by SCOREBOARD_RF_BYPASS_EN.
module rf_read_port #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic [AW-1:0]   rs_idx,
  input  logic [XLEN-1:0] rf_data,
  input  logic            busy,
  input  logic            write_enable,
  input  logic [AW-1:0]   rd,
`ifdef SCOREBOARD_RF_BYPASS_EN
  input  logic [XLEN-1:0] rd_din,
`endif
  output logic [XLEN-1:0] dout,
  output logic            hazard
);

  logic wb_hit;

  // Select read data and decide whether the source still waits on a producer
  always_comb begin
    wb_hit = write_enable && (rd == rs_idx);
    dout   = rf_data;
    hazard = busy;
`ifdef SCOREBOARD_RF_BYPASS_EN
    // The writeback resolves the dependency this very cycle
    if (wb_hit) begin
      dout   = rd_din;
      hazard = 1'b0;
    end
`else
    // Value lands in the array only at the edge, so hold decode one more cycle
    hazard = busy || wb_hit;
`endif
    if (rs_idx == '0) begin
      dout   = '0;
      hazard = 1'b0;
    end
  end

endmodule

// File: rtl/scoreboard_register_file.sv
// Integer register file with NUM_READ async read ports, one sync write port,
// a per-register busy scoreboard with population counter, and a sticky ecall
// halt detector. Define SCOREBOARD_RF_BYPASS_EN to forward same-cycle
// writeback data to the read ports and the halt check.
module scoreboard_register_file
  import rf_pkg::*;
#(
  parameter int unsigned          XLEN     = rf_pkg::XLEN,
  parameter int unsigned          NUM_REGS = rf_pkg::NUM_REGS,
  parameter int unsigned          NUM_READ = 2,
  parameter int unsigned          SP_IDX   = rf_pkg::SP_IDX,
  parameter logic [XLEN-1:0]      SP_INIT  = rf_pkg::SP_INIT,
  parameter int unsigned          HALT_REG = rf_pkg::HALT_REG,
  parameter int unsigned          HALT_VAL = rf_pkg::HALT_VAL,
  localparam int unsigned         AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_READ*AW-1:0]   rs,
  output logic [NUM_READ*XLEN-1:0] rs_dout,
  output logic [NUM_READ-1:0]      rs_hazard,
  input  logic [AW-1:0]            rd,
  input  logic [XLEN-1:0]          rd_din,
  input  logic                     write_enable,
  input  logic                     issue_valid,
  input  logic [AW-1:0]            issue_rd,
  input  logic                     is_ecall,
  output logic                     stall,
  output logic [AW:0]              busy_count,
  output logic                     is_halted
);

  localparam logic [AW-1:0]   HaltIdx  = AW'(HALT_REG);
  localparam logic [XLEN-1:0] HaltValW = XLEN'(HALT_VAL);

  logic [XLEN-1:0]     rf_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [AW:0]         busy_count_q, busy_count_d;
  logic                halt_q, halt_d;

  logic set_en, clr_en, cnt_inc, cnt_dec;
  logic [XLEN-1:0] halt_eff;

  // Register array; reset loads SP with its initial stack top
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (write_enable && (rd != '0)) begin
      rf_q[rd] <= rd_din;
    end
  end

  // Scoreboard next state; a same-cycle issue overrides the writeback clear
  always_comb begin
    set_en = issue_valid && (issue_rd != '0);
    clr_en = write_enable && (rd != '0);
    busy_d = busy_q;
    if (clr_en) busy_d[rd] = 1'b0;
    if (set_en) busy_d[issue_rd] = 1'b1;
    // Net popcount change, derived from which bits actually flip
    cnt_inc = set_en && !busy_q[issue_rd];
    cnt_dec = clr_en && busy_q[rd] && !(set_en && (issue_rd == rd));
    busy_count_d = busy_count_q;
    if (cnt_inc && !cnt_dec) begin
      busy_count_d = busy_count_q + 1'b1;
    end else if (cnt_dec && !cnt_inc) begin
      busy_count_d = busy_count_q - 1'b1;
    end
  end

  // Halt compare against the value a7 effectively holds this cycle
  always_comb begin
    halt_eff = rf_q[HaltIdx];
`ifdef SCOREBOARD_RF_BYPASS_EN
    if (write_enable && (rd != '0) && (rd == HaltIdx)) halt_eff = rd_din;
`endif
    halt_d = halt_q || (is_ecall && (halt_eff == HaltValW));
  end

  // Scoreboard, counter and sticky halt state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q       <= '0;
      busy_count_q <= '0;
      halt_q       <= 1'b0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
      halt_q       <= halt_d;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_port
    logic [AW-1:0] idx;
    assign idx = rs[k*AW +: AW];

    rf_read_port #(
      .XLEN (XLEN),
      .AW   (AW)
    ) u_port (
      .rs_idx       (idx),
      .rf_data      (rf_q[idx]),
      .busy         (busy_q[idx]),
      .write_enable (write_enable),
      .rd           (rd),
`ifdef SCOREBOARD_RF_BYPASS_EN
      .rd_din       (rd_din),
`endif
      .dout         (rs_dout[k*XLEN +: XLEN]),
      .hazard       (rs_hazard[k])
    );
  end

  assign stall      = |rs_hazard;
  assign busy_count = busy_count_q;
  assign is_halted  = halt_q;

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// against a behavioural model of the register file, scoreboard and halt.
module tb_scoreboard_register_file;

  localparam int NR = 4;
  localparam int AW = 5;
  localparam int XL = 32;

  logic              clk;
  logic              reset;
  logic [NR*AW-1:0]  rs;
  logic [NR*XL-1:0]  rs_dout;
  logic [NR-1:0]     rs_hazard;
  logic [AW-1:0]     rd;
  logic [XL-1:0]     rd_din;
  logic              write_enable;
  logic              issue_valid;
  logic [AW-1:0]     issue_rd;
  logic              is_ecall;
  logic              stall;
  logic [AW:0]       busy_count;
  logic              is_halted;

  scoreboard_register_file #(
    .NUM_READ (NR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rs           (rs),
    .rs_dout      (rs_dout),
    .rs_hazard    (rs_hazard),
    .rd           (rd),
    .rd_din       (rd_din),
    .write_enable (write_enable),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .is_ecall     (is_ecall),
    .stall        (stall),
    .busy_count   (busy_count),
    .is_halted    (is_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_rf [32];
  bit          m_busy [32];
  bit          m_halt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SCOREBOARD_RF_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_rf[i]   = (i == 2) ? 32'h2ffc : 32'h0;
      m_busy[i] = 1'b0;
    end
    m_halt = 1'b0;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += m_busy[i];
    return c;
  endfunction

  function automatic bit wb_hits(input int idx);
    return write_enable && (rd != 0) && (int'(rd) == idx);
  endfunction

  function automatic logic [31:0] exp_dout(input int idx);
    if (idx == 0) return 32'h0;
    if (Bypass && wb_hits(idx)) return rd_din;
    return m_rf[idx];
  endfunction

  function automatic bit exp_haz(input int idx);
    if (idx == 0) return 1'b0;
    if (Bypass) return m_busy[idx] && !wb_hits(idx);
    return m_busy[idx] || wb_hits(idx);
  endfunction

  // Compare every output against the model for the currently driven inputs
  task automatic check_all(input string tag);
    bit any_haz;
    #1;
    any_haz = 1'b0;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = int'(rs[k*AW +: AW]);
      chk($sformatf("%s dout%0d x%0d", tag, k, idx), 64'(rs_dout[k*XL +: XL]),
          64'(exp_dout(idx)));
      chk($sformatf("%s haz%0d x%0d", tag, k, idx), 64'(rs_hazard[k]), 64'(exp_haz(idx)));
      any_haz |= exp_haz(idx);
    end
    chk({tag, " stall"}, 64'(stall), 64'(any_haz));
    chk({tag, " busy_count"}, 64'(busy_count), 64'(model_count()));
    chk({tag, " is_halted"}, 64'(is_halted), 64'(m_halt));
  endtask

  // Advance one clock edge and apply the same edge to the model
  task automatic tick();
    logic [31:0] a7;
    a7 = (Bypass && wb_hits(17)) ? rd_din : m_rf[17];
    @(posedge clk);
    #1;
    if (reset) begin
      model_reset();
    end else begin
      if (is_ecall && a7 == 32'd10) m_halt = 1'b1;
      if (write_enable && rd != 0) begin
        m_rf[rd]   = rd_din;
        m_busy[rd] = 1'b0;
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    end
  endtask

  task automatic idle();
    write_enable = 1'b0;
    issue_valid  = 1'b0;
    is_ecall     = 1'b0;
    rd           = '0;
    rd_din       = '0;
    issue_rd     = '0;
  endtask

  task automatic set_rs(input int a, input int b, input int c, input int d);
    rs = {AW'(d), AW'(c), AW'(b), AW'(a)};
  endtask

  task automatic rand_rs();
    for (int k = 0; k < NR; k++) rs[k*AW +: AW] = AW'($urandom_range(0, 31));
  endtask

  initial begin
    reset = 1'b1;
    idle();
    set_rs(2, 0, 5, 17);
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    chk("reset sp", 64'(rs_dout[0 +: XL]), 64'h2ffc);
    reset = 1'b0;

    // Write x5=7, then reset asynchronously with a write and issue in flight
    write_enable = 1'b1; rd = 5'd5; rd_din = 32'd7;
    tick();
    idle();
    set_rs(5, 2, 0, 0);
    check_all("x5 written");
    chk("x5 value", 64'(rs_dout[0 +: XL]), 64'd7);
    write_enable = 1'b1; rd = 5'd6; rd_din = 32'h99;
    issue_valid  = 1'b1; issue_rd = 5'd7;
    reset = 1'b1;
    model_reset();
    check_all("reset async");
    chk("reset async x5", 64'(rs_dout[0 +: XL]), 64'd0);
    chk("reset async sp", 64'(rs_dout[XL +: XL]), 64'h2ffc);
    chk("reset async count", 64'(busy_count), 64'd0);
    tick();
    reset = 1'b0;
    idle();
    set_rs(6, 7, 5, 2);
    check_all("after reset");
    chk("dropped write x6", 64'(rs_dout[0 +: XL]), 64'd0);

    // Write to x0 is ignored
    write_enable = 1'b1; rd = 5'd0; rd_din = 32'hdead;
    set_rs(0, 0, 0, 0);
    check_all("x0 write");
    tick();
    idle();
    check_all("x0 after");
    chk("x0 reads zero", 64'(rs_dout[0 +: XL]), 64'd0);

    // Issue x3 then write it back
    issue_valid = 1'b1; issue_rd = 5'd3;
    set_rs(3, 0, 0, 0);
    tick();
    idle();
    check_all("x3 busy");
    chk("x3 hazard", 64'(rs_hazard[0]), 64'd1);
    chk("x3 stall", 64'(stall), 64'd1);
    chk("x3 count", 64'(busy_count), 64'd1);
    write_enable = 1'b1; rd = 5'd3; rd_din = 32'h55;
    check_all("x3 wb cycle");
    chk("x3 wb hazard", 64'(rs_hazard[0]), Bypass ? 64'd0 : 64'd1);
    tick();
    idle();
    check_all("x3 after wb");
    chk("x3 cleared", 64'(rs_hazard[0]), 64'd0);
    chk("x3 data", 64'(rs_dout[0 +: XL]), 64'h55);

    // Set wins over clear on x4
    issue_valid = 1'b1; issue_rd = 5'd4;
    set_rs(4, 3, 0, 0);
    tick();
    check_all("x4 busy");
    write_enable = 1'b1; rd = 5'd4; rd_din = 32'h44;
    check_all("x4 set+clr");
    tick();
    idle();
    check_all("x4 still busy");
    chk("x4 hazard kept", 64'(rs_hazard[0]), 64'd1);
    chk("x4 count kept", 64'(busy_count), 64'd1);
    write_enable = 1'b1; rd = 5'd4; rd_din = 32'h45;
    tick();
    idle();
    check_all("x4 drained");

    // Halt control: a7=9 must not halt
    write_enable = 1'b1; rd = 5'd17; rd_din = 32'd9;
    tick();
    idle();
    is_ecall = 1'b1;
    tick();
    idle();
    set_rs(17, 0, 0, 0);
    check_all("halt ctrl");
    chk("no halt a7=9", 64'(is_halted), 64'd0);

    // Halt: a7=10 then ecall
    write_enable = 1'b1; rd = 5'd17; rd_din = 32'd10;
    tick();
    idle();
    is_ecall = 1'b1;
    check_all("ecall cycle");
    chk("halt not yet", 64'(is_halted), 64'd0);
    tick();
    idle();
    check_all("halted");
    chk("halt set", 64'(is_halted), 64'd1);
    tick();
    tick();
    check_all("halt sticky");
    chk("halt still set", 64'(is_halted), 64'd1);

    // Clear halt and restore a clean state before the stress phase
    reset = 1'b1;
    model_reset();
    tick();
    reset = 1'b0;
    check_all("re-reset");

    // Issue x1..x31 on consecutive cycles with random reads
    for (int i = 1; i < 32; i++) begin
      issue_valid = 1'b1; issue_rd = AW'(i);
      rand_rs();
      check_all("fill");
      tick();
    end
    idle();
    rand_rs();
    check_all("full");
    chk("count 31", 64'(busy_count), 64'd31);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      write_enable = 1'($urandom_range(0, 1));
      rd           = AW'($urandom_range(0, 31));
      rd_din       = ($urandom_range(0, 3) == 0) ? 32'd10 : $urandom;
      issue_valid  = 1'($urandom_range(0, 1));
      issue_rd     = AW'($urandom_range(0, 31));
      is_ecall     = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) rd = AW'(17);
      rand_rs();
      if ($urandom_range(0, 2) == 0) rs[AW +: AW] = rd;
      check_all("rand");
      tick();
    end

    // Write back every register; scoreboard must drain to zero
    for (int i = 1; i < 32; i++) begin
      idle();
      write_enable = 1'b1; rd = AW'(i); rd_din = $urandom;
      rand_rs();
      check_all("drain");
      tick();
    end
    idle();
    rand_rs();
    check_all("drained");
    chk("count 0", 64'(busy_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scoreboard_register_file.md
Name: scoreboard_register_file

Overview:
- Parametrised successor of the CPU integer register file.
- Provides NUM_READ asynchronous read ports and one synchronous write port, with x0 hardwired to zero.
- Adds a per-register busy scoreboard for the pipelined core: registers are set busy at issue and cleared at writeback.
- Per-port hazard flags feed the decode-stage stall logic. A sticky, registered ecall halt detector is included.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, register count; must be a power of two, at least 2.
- AW, $clog2(NUM_REGS), register index width (derived; do not override).
- NUM_READ, 2, number of read ports (1..4).
- SP_IDX, 2, index of the stack pointer register.
- SP_INIT, 32'h2ffc, stack pointer value after reset.
- HALT_REG, 17, register compared on ecall (a7).
- HALT_VAL, 10, value of HALT_REG that means halt.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- rs  in  NUM_READ*AW  read indices; port k occupies bits [k*AW +: AW]
- rs_dout  out  NUM_READ*XLEN  read data; port k occupies bits [k*XLEN +: XLEN]
- rs_hazard  out  NUM_READ  port k's source register has an outstanding producer
- rd  in  AW  writeback destination index
- rd_din  in  XLEN  writeback data
- write_enable  in  1  writeback strobe (RegWrite)
- issue_valid  in  1  an instruction writing issue_rd is leaving decode this cycle
- issue_rd  in  AW  destination index of the issuing instruction
- is_ecall  in  1  ecall is in decode this cycle
- stall  out  1  OR-reduction of rs_hazard
- busy_count  out  AW+1  number of registers currently busy
- is_halted  out  1  sticky halt flag

Behaviour:
- Reset (asynchronous, immediate):
  - All registers are 0, except register SP_IDX, which is SP_INIT.
  - All busy bits are 0, busy_count is 0, is_halted is 0.
  - If reset is asserted mid-operation, any in-flight write or issue in that cycle is discarded.
- Write:
  - On a rising edge with write_enable=1 and rd!=0, rf[rd] <= rd_din.
  - Writes to index 0 are ignored; rf[0] always reads 0.
- Read: rs_dout[k] is combinational from rf[rs[k]]; index 0 returns 0. Bypass on a same-cycle write is defined under Optional Feature.
- Scoreboard set/clear:
  - On a rising edge, busy[issue_rd] is set when issue_valid=1 and issue_rd!=0.
  - On a rising edge, busy[rd] is cleared when write_enable=1 and rd!=0.
  - Same register set and cleared in the same cycle: set wins, because the new producer supersedes the old one.
  - Writeback to a register that is not busy is legal; the data is written and busy stays 0.
  - Issue to a register that is already busy is legal (WAW); the bit stays 1.
- Hazard and stall:
  - rs_hazard[k] = busy[rs[k]] and rs[k]!=0, with the bypass adjustment described under Optional Feature.
  - stall = |rs_hazard.
- busy_count:
  - Registered counter, updated each edge by +1, -1 or 0 according to the net change of busy bits.
  - Must always equal the popcount of busy, including in the set-wins case.
  - Range is 0..NUM_REGS-1; it never wraps.
- Halt:
  - On a rising edge, is_halted <= 1 when is_ecall=1 and the effective value of HALT_REG equals HALT_VAL. The effective value includes bypass when bypass is enabled.
  - is_halted is sticky: only reset clears it.
  - Output latency is one cycle after the ecall.
- Latency summary: reads are 0 cycles; writes are visible through rf on the next cycle; busy and hazard changes are visible on the next cycle.

Optional Feature:
- Macro: SCOREBOARD_RF_BYPASS_EN.
- Defined:
  - If write_enable=1, rd!=0 and rs[k]==rd, then rs_dout[k]=rd_din in the same cycle.
  - In that case rs_hazard[k]=0, even if busy[rd] is set.
  - The halt check compares the bypassed value.
- Undefined:
  - Reads return the stored value only.
  - rs_hazard[k] = (busy[rs[k]] or (write_enable and rd==rs[k])) and rs[k]!=0, so a same-cycle writeback still stalls for one cycle.

Decomposition:
- Shared package rf_pkg holds the default constants XLEN, NUM_REGS, SP_IDX, SP_INIT, HALT_REG and HALT_VAL.
- Sub-module rf_read_port (one instance per read port) contains the index-0 mask, the bypass mux and the hazard logic.
- Storage, scoreboard, counter and halt logic stay in the top module.

Test Plan:
- Reset mid-run:
  - Stimulus: write x5=7, then assert reset.
  - Response: immediately rs_dout of x5 = 0, x2 = 0x2ffc, busy_count = 0, is_halted = 0.
- Write to x0: write_enable=1, rd=0, rd_din=0xdead -> reading rs=0 returns 0 and busy_count is unchanged.
- Issue then writeback:
  - Issue x3 -> next cycle rs_hazard for rs=3 is 1, stall=1, busy_count=1.
  - Write x3=0x55 -> with the macro, hazard is 0 and rs_dout=0x55 in that same cycle; without the macro, hazard is 1 in that cycle and 0 the next.
- Same-cycle issue and writeback to x4 while x4 is busy: busy[4] stays 1 and busy_count is unchanged.
- Halt:
  - Stimulus: write x17=10, then is_ecall=1 on the next cycle.
  - Response: is_halted=1 one cycle later and stays 1 after is_ecall drops.
  - Control case: with x17=9, is_halted stays 0.
- Multi-port stress with NUM_READ=4:
  - Stimulus: issue x1..x31 on consecutive cycles.
  - Response: busy_count reaches 31; randomised reads match the reference-model rs_dout and rs_hazard values; writing back all registers returns busy_count to 0.
